// File: rtl/reg_file_mp.sv
// Multi-ported register file: NR registered read ports, two prioritised write ports, busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-edge write data to the read ports.
module reg_file_mp #(
    parameter int n  = 32,
    parameter int r  = 7,
    parameter int NR = 2
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic [1:0]      wrEn,
    input  logic [r-1:0]    wrAddr0,
    input  logic [r-1:0]    wrAddr1,
    input  logic [n-1:0]    wrData0,
    input  logic [n-1:0]    wrData1,
    input  logic            issueEn,
    input  logic [r-1:0]    issueReg,
    input  logic            rdEn,
    input  logic [NR*r-1:0] readRegs,
    output logic [NR*n-1:0] readData,
    output logic [NR-1:0]   readBusy
);

    localparam int DEPTH = 1 << r;

    logic [n-1:0]     r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [NR*n-1:0]  r_rd_data;
    logic [NR-1:0]    r_rd_busy;

    logic             w_we0;
    logic             w_we1;
    logic             w_iss;
    logic [r-1:0]     w_ra [NR];
    logic [NR*n-1:0]  w_rd_data;
    logic [NR-1:0]    w_rd_busy;

    // Address 0 is hard-wired: writes and issues to it are dropped here.
    assign w_we0 = wrEn[0] && (wrAddr0 != '0);
    assign w_we1 = wrEn[1] && (wrAddr1 != '0);
    assign w_iss = issueEn && (issueReg != '0);

    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int i = 0; i < NR; i++) begin
            w_ra[i] = readRegs[i*r +: r];
            if (w_ra[i] != '0) begin
`ifdef REGFILE_BYPASS_EN
                if (w_we1 && (wrAddr1 == w_ra[i]))
                    w_rd_data[i*n +: n] = wrData1;
                else if (w_we0 && (wrAddr0 == w_ra[i]))
                    w_rd_data[i*n +: n] = wrData0;
                else
                    w_rd_data[i*n +: n] = r_mem[w_ra[i]];
`else
                w_rd_data[i*n +: n] = r_mem[w_ra[i]];
`endif
                // Busy reflects this edge's update: a new issue beats a retiring write.
                if (w_iss && (issueReg == w_ra[i]))
                    w_rd_busy[i] = 1'b1;
                else if ((w_we0 && (wrAddr0 == w_ra[i])) || (w_we1 && (wrAddr1 == w_ra[i])))
                    w_rd_busy[i] = 1'b0;
                else
                    w_rd_busy[i] = r_busy[w_ra[i]];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_busy    <= '0;
            r_rd_data <= '0;
            r_rd_busy <= '0;
        end else begin
            if (w_we0) begin
                r_mem[wrAddr0]  <= wrData0;
                r_busy[wrAddr0] <= 1'b0;
            end
            // Port 1 is assigned last so it wins a same-address conflict.
            if (w_we1) begin
                r_mem[wrAddr1]  <= wrData1;
                r_busy[wrAddr1] <= 1'b0;
            end
            if (w_iss)
                r_busy[issueReg] <= 1'b1;
            if (rdEn) begin
                r_rd_data <= w_rd_data;
                r_rd_busy <= w_rd_busy;
            end
        end
    end

    assign readData = r_rd_data;
    assign readBusy = r_rd_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: driver pushes expected read results, monitor pops and compares.
module tb_reg_file_mp;

  localparam int N  = 32;
  localparam int R  = 7;
  localparam int NR = 2;
  localparam int W  = NR + NR*N;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            resetN = 1'b0;
  logic [1:0]      wrEn = '0;
  logic [R-1:0]    wrAddr0 = '0, wrAddr1 = '0;
  logic [N-1:0]    wrData0 = '0, wrData1 = '0;
  logic            issueEn = 1'b0;
  logic [R-1:0]    issueReg = '0;
  logic            rdEn = 1'b0;
  logic [NR*R-1:0] readRegs = '0;
  logic [NR*N-1:0] readData;
  logic [NR-1:0]   readBusy;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp = '0;
  int checks = 0;
  int failures = 0;

  // Handshake: no valid output; a read issued with rdEn=1 before edge T is
  // presented after edge T and held until the next rdEn edge.
  reg_file_mp #(.n(N), .r(R), .NR(NR)) dut (
    .clk(clk), .resetN(resetN), .wrEn(wrEn),
    .wrAddr0(wrAddr0), .wrAddr1(wrAddr1), .wrData0(wrData0), .wrData1(wrData1),
    .issueEn(issueEn), .issueReg(issueReg), .rdEn(rdEn), .readRegs(readRegs),
    .readData(readData), .readBusy(readBusy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // driver
  task automatic idle();
    wrEn = '0; issueEn = 1'b0; rdEn = 1'b0;
  endtask

  task automatic cyc(input logic [1:0] we,
                     input logic [R-1:0] wa0, input logic [N-1:0] wd0,
                     input logic [R-1:0] wa1, input logic [N-1:0] wd1,
                     input logic ie, input logic [R-1:0] ir,
                     input logic re, input logic [R-1:0] ra0, input logic [R-1:0] ra1,
                     input logic [N-1:0] ed0, input logic eb0,
                     input logic [N-1:0] ed1, input logic eb1);
    @(negedge clk);
    wrEn = we; wrAddr0 = wa0; wrData0 = wd0; wrAddr1 = wa1; wrData1 = wd1;
    issueEn = ie; issueReg = ir; rdEn = re; readRegs = {ra1, ra0};
    if (re) exp_q.push_back({eb1, eb0, ed1, ed0});
  endtask

  // scoreboard flush on reset: outputs must return to zero
  always @(negedge resetN) begin
    cur_exp = '0;
    exp_q.delete();
  end

  // monitor
  initial begin
    logic rd_s, rst_s;
    forever begin
      @(posedge clk);
      rd_s = rdEn;
      rst_s = resetN;
      #1;
      if (rst_s && resetN) begin
        if (rd_s) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL exp_q_underflow t=%0t", $time);
          end else begin
            cur_exp = exp_q.pop_front();
          end
        end
        check("read_out", {readBusy, readData}, cur_exp);
      end
    end
  end

  initial begin
    idle();
    repeat (3) @(negedge clk);
    resetN = 1'b1;

    // reset state
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 1, 7'd5, 7'd6, 32'h0, 0, 32'h0, 0);
    // write r5, issue r6, then read them back
    cyc(2'b01, 7'd5, 32'hDEADBEEF, 0, 0, 1, 7'd6, 0, 0, 0, 0, 0, 0, 0);
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 1, 7'd5, 7'd6, 32'hDEADBEEF, 0, 32'h0, 1);
    // mid-operation asynchronous reset
    @(negedge clk);
    idle();
    #2 resetN = 1'b0;
    #1 check("async_reset_out", {readBusy, readData}, '0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 1, 7'd5, 7'd6, 32'h0, 0, 32'h0, 0);

    // dual write conflict: port 1 wins
    cyc(2'b11, 7'd9, 32'h11, 7'd9, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 1, 7'd9, 7'd9, 32'h22, 0, 32'h22, 0);

    // forwarding from port 0, then stored value
    cyc(2'b01, 7'd3, 32'hA5A5A5A5, 0, 0, 0, 0, 1, 7'd3, 7'd9,
        BYP ? 32'hA5A5A5A5 : 32'h0, 0, 32'h22, 0);
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 1, 7'd3, 7'd3, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0);
    // forwarding priority: port 1 over port 0
    cyc(2'b11, 7'd4, 32'h1, 7'd4, 32'h2, 0, 0, 1, 7'd4, 7'd3,
        BYP ? 32'h2 : 32'h0, 0, 32'hA5A5A5A5, 0);
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 1, 7'd4, 7'd4, 32'h2, 0, 32'h2, 0);

    // register 0: writes/issue ignored, forwarded read still 0
    cyc(2'b11, 7'd0, 32'hFFFFFFFF, 7'd0, 32'hFFFFFFFF, 1, 7'd0, 1, 7'd0, 7'd0, 32'h0, 0, 32'h0, 0);
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 1, 7'd0, 7'd0, 32'h0, 0, 32'h0, 0);

    // scoreboard on r12
    cyc(2'b00, 0, 0, 0, 0, 1, 7'd12, 1, 7'd12, 7'd4, 32'h0, 1, 32'h2, 0);
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 1, 7'd12, 7'd12, 32'h0, 1, 32'h0, 1);
    cyc(2'b01, 7'd12, 32'h7, 0, 0, 0, 0, 1, 7'd12, 7'd12,
        BYP ? 32'h7 : 32'h0, 0, BYP ? 32'h7 : 32'h0, 0);
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 1, 7'd12, 7'd5, 32'h7, 0, 32'h0, 0);
    cyc(2'b10, 0, 0, 7'd12, 32'h8, 1, 7'd12, 1, 7'd12, 7'd12,
        BYP ? 32'h8 : 32'h7, 1, BYP ? 32'h8 : 32'h7, 1);
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 1, 7'd12, 7'd12, 32'h8, 1, 32'h8, 1);

    // hold: outputs frozen while r1 is rewritten with rdEn=0
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 1, 7'd1, 7'd12, 32'h0, 0, 32'h8, 1);
    for (int i = 0; i < 3; i++)
      cyc(2'b01, 7'd1, 32'h100 + i, 0, 0, 0, 0, 0, 7'd1, 7'd1, 0, 0, 0, 0);
    cyc(2'b00, 0, 0, 0, 0, 0, 0, 1, 7'd1, 7'd12, 32'h102, 0, 32'h8, 1);

    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL exp_q_drain got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
